// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one single-port parity RAM.
// Drives the RAM pins in the grant cycle and tags reads through the RAM's output latency.
module ram_arbiter #(
    parameter int MEM_WIDTH  = 16,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [MEM_WIDTH-1:0] wdata0,
    input  logic [MEM_WIDTH-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity,
    output logic                 rd_valid,
    output logic                 rd_id,
    output logic [MEM_WIDTH-1:0] rd_data,
    output logic                 rd_parity
);

    typedef struct packed {
        logic                 we;
        logic [ADDR_SIZE-1:0] addr;
        logic [MEM_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t                 cmd0, cmd1, cmd_g;
    logic                 last;
    logic                 gnt_any;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [MEM_WIDTH-1:0] din_q;
    logic [RD_LATENCY:1]  vld_q, id_q;
    logic [RD_LATENCY:0]  vld_pipe, id_pipe;

    assign cmd0 = '{we: we0, addr: addr0, wdata: wdata0};
    assign cmd1 = '{we: we1, addr: addr1, wdata: wdata1};

    // On a tie, the requester that did not win last time goes first.
    assign gnt0    = !rst && req0 && (!req1 || last);
    assign gnt1    = !rst && req1 && (!req0 || !last);
    assign gnt_any = gnt0 | gnt1;
    assign cmd_g   = gnt1 ? cmd1 : cmd0;

    assign ram_blk_select = gnt_any;
    assign ram_wr_en      = gnt_any && cmd_g.we;
    assign ram_rd_en      = gnt_any && !cmd_g.we;
    assign ram_addr       = gnt_any ? cmd_g.addr : addr_q;
    assign ram_din        = ram_wr_en ? cmd_g.wdata : din_q;
    assign ram_addr_en    = 1'b1;
    assign ram_dout_en    = 1'b1;

    // Stage 0 is the issue cycle itself; stage RD_LATENCY lines up with valid ram_dout.
    assign vld_pipe = {vld_q, ram_rd_en};
    assign id_pipe  = {id_q, gnt1};

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            vld_q     <= '0;
            id_q      <= '0;
            rd_valid  <= 1'b0;
            rd_id     <= 1'b0;
            rd_data   <= '0;
            rd_parity <= 1'b0;
        end else begin
            if (gnt_any) begin
                last   <= gnt1;
                addr_q <= cmd_g.addr;
            end
            if (ram_wr_en)
                din_q <= cmd_g.wdata;
            vld_q    <= vld_pipe[RD_LATENCY-1:0];
            id_q     <= id_pipe[RD_LATENCY-1:0];
            rd_valid <= vld_pipe[RD_LATENCY];
            if (vld_pipe[RD_LATENCY]) begin
                rd_data   <= ram_dout;
                rd_parity <= ram_parity;
                rd_id     <= id_pipe[RD_LATENCY];
            end
        end
    end

endmodule
